// File: rtl/sdram_prefetch_buffer.sv
// sdram_prefetch_buffer: DEPTH-entry sequential stream buffer in front
// of sdram_controller; demand reads that hit the head return in one cycle.
module sdram_prefetch_buffer #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter bit PF_EN    = 1'b1,
  parameter bit ROW_STOP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_in_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_out_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT_WAIT,
    S_MISS_DRAIN,
    S_DEMAND,
    S_WRITE
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] head_addr, nxt_addr, dem_addr;
  logic [DATA_W-1:0] dem_wdata;
  logic              stream, inflight, wr_pend, wr_seen, alive;

  logic              acc, rd_acc, wr_acc, hit, pf_match;
  logic              mem_free, pf_ok;
  logic              issue, iss_rw;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic              push, pop, flush;
  logic              rsp_set;
  logic [DATA_W-1:0] rsp_data;
  logic              head_adv, head_load, wr_done;

  assign req_ready = alive && (state == S_IDLE);
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_rw;
  assign wr_acc    = acc && req_rw;

  assign hit = rd_acc && (count != '0) &&
               (req_addr[ADDR_W-1:2] == head_addr[ADDR_W-1:2]);

  // in S_IDLE any read in flight is a prefetch at mem_addr
  assign pf_match = rd_acc && (count == '0) && inflight &&
                    (req_addr[ADDR_W-1:2] == mem_addr[ADDR_W-1:2]);

  assign mem_free = !inflight && !mem_busy && !wr_pend;

  assign nxt_addr = head_addr +
                    ((ADDR_W'(count) + ADDR_W'(inflight)) << 2);

  assign pf_ok = PF_EN && stream &&
                 (((CW+1)'(count) + (CW+1)'(inflight)) < (CW+1)'(DEPTH)) &&
                 (!ROW_STOP || (nxt_addr[9:0] != '0));

  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    iss_rw    = 1'b0;
    iss_addr  = dem_addr;
    iss_wdata = dem_wdata;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    rsp_set   = 1'b0;
    rsp_data  = mem_rdata;
    head_adv  = 1'b0;
    head_load = 1'b0;
    wr_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        push = inflight && mem_out_valid && !pf_match;
        if (wr_acc) begin
          state_nx = S_WRITE;
          flush    = 1'b1;
        end else if (hit) begin
          pop      = 1'b1;
          rsp_set  = 1'b1;
          rsp_data = buf_q[rd_ptr];
          head_adv = 1'b1;
        end else if (pf_match) begin
          // fetch returning this very cycle is forwarded directly
          if (mem_out_valid) begin
            rsp_set  = 1'b1;
            head_adv = 1'b1;
          end else begin
            state_nx = S_HIT_WAIT;
          end
        end else if (rd_acc) begin
          state_nx = S_MISS_DRAIN;
          flush    = 1'b1;
        end
        if (mem_free && pf_ok && (!acc || hit)) begin
          issue    = 1'b1;
          iss_addr = nxt_addr;
        end
      end
      S_HIT_WAIT: begin
        if (mem_out_valid) begin
          rsp_set  = 1'b1;
          head_adv = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_MISS_DRAIN: begin
        if (mem_free) begin
          issue    = 1'b1;
          state_nx = S_DEMAND;
        end
      end
      S_DEMAND: begin
        if (mem_out_valid) begin
          rsp_set   = 1'b1;
          head_load = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wr_pend) begin
          if (wr_seen && !mem_busy) begin
            wr_done  = 1'b1;
            state_nx = S_IDLE;
          end
        end else if (mem_free) begin
          issue  = 1'b1;
          iss_rw = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      alive        <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      head_addr    <= '0;
      dem_addr     <= '0;
      dem_wdata    <= '0;
      stream       <= 1'b0;
      inflight     <= 1'b0;
      wr_pend      <= 1'b0;
      wr_seen      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      mem_in_valid <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      alive        <= 1'b1;
      state        <= state_nx;
      mem_in_valid <= issue;
      rsp_valid    <= rsp_set;
      if (acc) begin
        dem_addr  <= req_addr & ~ADDR_W'(3);
        dem_wdata <= req_wdata;
      end
      if (issue) begin
        mem_rw    <= iss_rw;
        mem_addr  <= iss_addr;
        mem_wdata <= iss_wdata;
      end
      if (rsp_set) rsp_rdata <= rsp_data;
      if (issue && !iss_rw) inflight <= 1'b1;
      else if (mem_out_valid) inflight <= 1'b0;
      if (issue && iss_rw) wr_pend <= 1'b1;
      else if (wr_done) wr_pend <= 1'b0;
      if (issue || wr_done) wr_seen <= 1'b0;
      else if (wr_pend && mem_busy) wr_seen <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (head_load) head_addr <= dem_addr + ADDR_W'(4);
      else if (head_adv) head_addr <= head_addr + ADDR_W'(4);
      if (head_load) stream <= 1'b1;
      else if (flush) stream <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) buf_q[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_sdram_prefetch_buffer.sv
// tb_sdram_prefetch_buffer: directed stream/miss/write/row tests with a
// memory-content scoreboard and a simple sdram_controller model.
module tb_sdram_prefetch_buffer;

  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_in_valid;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_busy = 1'b0;
  logic          mem_out_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  sdram_prefetch_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_in_valid (mem_in_valid),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_busy     (mem_busy),
    .mem_out_valid(mem_out_valid),
    .mem_rdata    (mem_rdata)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_w[int];
  logic [AW:0]   mlog[$];
  logic [DW-1:0] last_rdata = '0;
  logic          rsp_after_ov = 1'b0;
  logic          ov_prev = 1'b0;
  int            rd_out = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    int k;
    k = int'(a[AW-1:2]);
    if (ref_w.exists(k)) return ref_w[k];
    return 32'hC0DE0000 + DW'(a);
  endfunction

  function automatic int cnt_addr(input logic [AW:0] v);
    int c;
    c = 0;
    foreach (mlog[i]) if (mlog[i] == v) c++;
    return c;
  endfunction

  // controller model: busy for LAT cycles, read data pulse at the end
  logic [DW-1:0] cmem [1024];
  logic          c_rw = 1'b0;
  logic [AW-1:0] c_a = '0;
  int            c_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        mem_busy      <= 1'b0;
        mem_out_valid <= 1'b0;
        mem_rdata     <= '0;
        c_cnt         <= 0;
        for (int i = 0; i < 1024; i++)
          cmem[i] <= 32'hC0DE0000 + 32'(i * 4);
      end else begin
        mem_out_valid <= 1'b0;
        if (mem_in_valid) begin
          mem_busy <= 1'b1;
          c_cnt    <= LAT;
          c_rw     <= mem_rw;
          c_a      <= mem_addr;
          if (mem_rw) cmem[mem_addr[11:2]] <= mem_wdata;
        end else if (mem_busy) begin
          if (c_cnt == 1) begin
            mem_busy <= 1'b0;
            if (!c_rw) begin
              mem_out_valid <= 1'b1;
              mem_rdata     <= cmem[c_a[11:2]];
            end
          end else begin
            c_cnt <= c_cnt - 1;
          end
        end
      end
    end
  end

  // compare process: responses vs scoreboard, one-outstanding rule
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_out  = 0;
        ov_prev = 1'b0;
      end else begin
        if (mem_out_valid && rd_out > 0) rd_out--;
        if (mem_in_valid) begin
          check("one_outstanding", {mem_busy, rd_out != 0}, 0);
          mlog.push_back({mem_rw, mem_addr});
          if (!mem_rw) rd_out++;
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_spurious", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_rdata, e);
          end
          last_rdata   = rsp_rdata;
          rsp_after_ov = ov_prev;
        end
        ov_prev = mem_out_valid;
      end
    end
  end

  task automatic rd(input logic [AW-1:0] a, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = a;
    req_wdata = '0;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    if (!req_ready) begin
      check("rd_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(ref_rd(a));
    @(posedge clk);
    #1 req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) check("rd_rsp_timeout", 0, 1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("wr_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    ref_w[int'(a[AW-1:2])] = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_rw = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) check("wr_done_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rsp"}, {rsp_valid, rsp_rdata}, 0);
    check({tag, "_mem"}, {mem_in_valid, mem_rw, mem_addr, mem_wdata}, 0);
  endtask

  initial begin
    int lat, idx, n, msz;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // sequential stream from 0x000
    rd(23'h000, lat);
    check("seq0_miss", lat > 1, 1);
    check("seq0_data", last_rdata, 32'hC0DE0000);
    idle(40);
    for (int i = 1; i <= 4; i++) begin
      rd(AW'(i * 4), lat);
      check("seq_hit_lat", lat, 1);
    end
    check("seq4_data", last_rdata, 32'hC0DE0010);
    idle(40);
    for (int i = 0; i < 6; i++) begin
      if (i < mlog.size()) check("seq_mem_addr", mlog[i], {1'b0, AW'(i * 4)});
      else check("seq_mem_len", mlog.size(), 6);
    end

    // hit-under-fetch: 0x044 demanded while its prefetch is in flight
    rd(23'h040, lat);
    check("huf_lead_miss", lat > 1, 1);
    rd(23'h044, lat);
    check("huf_rsp_after_ov", rsp_after_ov, 1);
    check("huf_data", last_rdata, 32'hC0DE0044);
    idle(5);
    check("huf_single_fetch", cnt_addr({1'b0, 23'h044}), 1);

    // miss while the 0x204 prefetch is in flight
    rd(23'h200, lat);
    rd(23'h800, lat);
    check("drain_miss", lat > 1, 1);
    check("drain_data", last_rdata, 32'hC0DE0800);
    idx = -1;
    foreach (mlog[i]) if (mlog[i] == {1'b0, 23'h204}) idx = i;
    if (idx >= 0 && idx + 1 < mlog.size())
      check("drain_next_addr", mlog[idx+1], {1'b0, 23'h800});
    else
      check("drain_pf_seen", idx, 0);

    // write invalidates buffered 0x010..0x01C
    rd(23'h00C, lat);
    idle(40);
    wr(23'h014, 32'hDEADBEEF);
    rd(23'h014, lat);
    check("wi_miss", lat > 1, 1);
    check("wi_data", last_rdata, 32'hDEADBEEF);
    idx = -1;
    foreach (mlog[i]) if (mlog[i] == {1'b1, 23'h014}) idx = i;
    if (idx >= 0 && idx + 1 < mlog.size())
      check("wi_next_rd", mlog[idx+1], {1'b0, 23'h014});
    else
      check("wi_write_seen", idx, 0);

    // row stop at the 1 KB boundary
    rd(23'h3F4, lat);
    idle(60);
    check("row_no_400", cnt_addr({1'b0, 23'h400}), 0);
    check("row_last_3fc", mlog[$], {1'b0, 23'h3FC});
    rd(23'h3F8, lat);
    check("row_hit_3f8", lat, 1);
    rd(23'h3FC, lat);
    check("row_hit_3fc", lat, 1);
    idle(20);
    check("row_still_no_400", cnt_addr({1'b0, 23'h400}), 0);
    rd(23'h400, lat);
    check("row_400_miss", lat > 1, 1);
    check("row_400_once", cnt_addr({1'b0, 23'h400}), 1);

    // reset with three buffered words and 0x010 in flight
    rd(23'h000, lat);
    n = 0;
    while (!(mlog.size() > 0 && mlog[$] == {1'b0, 23'h010}) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_pf_010_seen", mlog[$], {1'b0, 23'h010});
    rst = 1'b0;
    #1 chk_zero("mid_reset");
    idle(3);
    rst = 1'b1;
    idle(2);
    msz = mlog.size();
    rd(23'h100, lat);
    check("mid_100_miss", lat > 1, 1);
    if (msz < mlog.size()) check("mid_100_addr", mlog[msz], {1'b0, 23'h100});
    else check("mid_100_issued", mlog.size(), msz + 1);
    check("mid_100_data", last_rdata, 32'hC0DE0100);

    idle(10);
    check("all_rsp_returned", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
